// File: rtl/rat_io_pkg.sv
// RAT I/O responder shared definitions.
// Port-ID map and button count used by the bus responder.
package rat_io_pkg;

  localparam logic [7:0] PID_SW_LO    = 8'h20;
  localparam logic [7:0] PID_SW_HI    = 8'h21;
  localparam logic [7:0] PID_BTN      = 8'h24;
  localparam logic [7:0] PID_LED_LO   = 8'h40;
  localparam logic [7:0] PID_LED_HI   = 8'h41;
  localparam logic [7:0] PID_INT_MASK = 8'h7D;
  localparam logic [7:0] PID_INT_PEND = 8'h7E;
  localparam logic [7:0] PID_INT_ACK  = 8'h7F;
  localparam logic [7:0] PID_SSEG     = 8'h81;

  localparam int NUM_BTN = 4;

endpackage

// File: rtl/rat_debounce.sv
// Single-bit synchronizer and debouncer.
// Level is accepted only after it differs for DEBOUNCE_CYCLES cycles.
module rat_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

  // Count cycles of disagreement; flip the output once it lasts long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rat_io_responder.sv
// RAT CPU I/O bus responder for the Basys3 board.
// Output registers, input decode, button debounce and interrupt logic.
module rat_io_responder
  import rat_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  PORT_ID,
  input  logic [7:0]  OUT_PORT,
  input  logic        IO_STRB,
  output logic [7:0]  IN_PORT,
  output logic        INT,
  input  logic [15:0] SWITCHES,
  input  logic [3:0]  BUTTONS,
  output logic [15:0] LEDS,
  output logic [7:0]  SSEG_VAL
);

  logic [15:0]        sw_meta;
  logic [15:0]        sw_sync;
  logic [NUM_BTN-1:0] btn_db;
  logic [NUM_BTN-1:0] btn_db_q;
  logic [NUM_BTN-1:0] btn_rise;
  logic [NUM_BTN-1:0] int_mask;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] ack;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    rat_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (CLK),
      .reset(RESET),
      .raw  (BUTTONS[i]),
      .level(btn_db[i])
    );
  end

  assign btn_rise = btn_db & ~btn_db_q;
  assign ack = (IO_STRB && PORT_ID == PID_INT_ACK) ?
               OUT_PORT[3:0] : '0;

  // Switch synchronizer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SWITCHES;
      sw_sync <= sw_meta;
    end
  end

  // CPU-writable output registers and interrupt mask.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      LEDS     <= '0;
      SSEG_VAL <= '0;
      int_mask <= '0;
    end else if (IO_STRB) begin
      case (PORT_ID)
        PID_LED_LO:   LEDS[7:0]  <= OUT_PORT;
        PID_LED_HI:   LEDS[15:8] <= OUT_PORT;
        PID_SSEG:     SSEG_VAL   <= OUT_PORT;
        PID_INT_MASK: int_mask   <= OUT_PORT[3:0];
        default:      ;
      endcase
    end
  end

  // Press-event latch; a new press beats a same-cycle acknowledge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_db_q <= '0;
      pending  <= '0;
      INT      <= 1'b0;
    end else begin
      btn_db_q <= btn_db;
      pending  <= (pending & ~ack) | btn_rise;
      INT      <= |(pending & int_mask);
    end
  end

  // Zero-latency read decode.
  always_comb begin
    IN_PORT = 8'h00;
    case (PORT_ID)
      PID_SW_LO:    IN_PORT = sw_sync[7:0];
      PID_SW_HI:    IN_PORT = sw_sync[15:8];
      PID_BTN:      IN_PORT = {4'b0, btn_db};
      PID_INT_MASK: IN_PORT = {4'b0, int_mask};
      PID_INT_PEND: IN_PORT = {4'b0, pending};
      default:      IN_PORT = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_rat_io_responder.sv
// Self-checking bench for rat_io_responder.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_rat_io_responder;

  localparam int DC = 8;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic        IO_STRB;
  logic [7:0]  IN_PORT;
  logic        INT;
  logic [15:0] SWITCHES;
  logic [3:0]  BUTTONS;
  logic [15:0] LEDS;
  logic [7:0]  SSEG_VAL;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_leds;
  logic [7:0]  m_sseg;
  logic [3:0]  m_mask;
  logic [3:0]  m_pend;

  rat_io_responder #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .PORT_ID (PORT_ID),
    .OUT_PORT(OUT_PORT),
    .IO_STRB (IO_STRB),
    .IN_PORT (IN_PORT),
    .INT     (INT),
    .SWITCHES(SWITCHES),
    .BUTTONS (BUTTONS),
    .LEDS    (LEDS),
    .SSEG_VAL(SSEG_VAL)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic io_write(input logic [7:0] id,
                          input logic [7:0] d,
                          input logic strb);
    PORT_ID  = id;
    OUT_PORT = d;
    IO_STRB  = strb;
    step(1);
    IO_STRB  = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] id,
                         output logic [7:0] d);
    PORT_ID = id;
    #1;
    d = IN_PORT;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    RESET = 1'b1;
    step(2);
    RESET = 1'b0;
    io_read(8'h7E, r);
    checks++;
    if (LEDS !== 16'h0) begin
      errors++;
      $display("FAIL reset_leds got %h want 0000", LEDS);
    end
    checks++;
    if (SSEG_VAL !== 8'h0) begin
      errors++;
      $display("FAIL reset_sseg got %h want 00", SSEG_VAL);
    end
    checks++;
    if (INT !== 1'b0) begin
      errors++;
      $display("FAIL reset_int got %b want 0", INT);
    end
    checks++;
    if (r !== 8'h00) begin
      errors++;
      $display("FAIL reset_pend got %h want 00", r);
    end
  endtask

  task automatic test_leds();
    io_write(8'h40, 8'hA5, 1'b1);
    io_write(8'h41, 8'h3C, 1'b1);
    checks++;
    if (LEDS !== 16'h3CA5) begin
      errors++;
      $display("FAIL led_write got %h want 3ca5", LEDS);
    end
    io_write(8'h40, 8'h11, 1'b0);
    io_write(8'h41, 8'h22, 1'b0);
    io_write(8'h81, 8'h33, 1'b0);
    step(1);
    checks++;
    if (LEDS !== 16'h3CA5) begin
      errors++;
      $display("FAIL led_nostrb got %h want 3ca5", LEDS);
    end
    io_write(8'h81, 8'h5A, 1'b1);
    checks++;
    if (SSEG_VAL !== 8'h5A) begin
      errors++;
      $display("FAIL sseg_write got %h want 5a", SSEG_VAL);
    end
  endtask

  task automatic test_switches();
    logic [7:0] r;
    SWITCHES = 16'hBEEF;
    step(3);
    io_read(8'h21, r);
    checks++;
    if (r !== 8'hBE) begin
      errors++;
      $display("FAIL sw_hi got %h want be", r);
    end
    io_read(8'h20, r);
    checks++;
    if (r !== 8'hEF) begin
      errors++;
      $display("FAIL sw_lo got %h want ef", r);
    end
    io_read(8'h55, r);
    checks++;
    if (r !== 8'h00) begin
      errors++;
      $display("FAIL unmapped got %h want 00", r);
    end
  endtask

  task automatic test_button_int();
    logic [7:0] r;
    io_write(8'h7D, 8'h01, 1'b1);
    BUTTONS[0] = 1'b1;
    step(5);
    BUTTONS[0] = 1'b0;
    step(20);
    checks++;
    if (INT !== 1'b0) begin
      errors++;
      $display("FAIL glitch_int got %b want 0", INT);
    end
    BUTTONS[0] = 1'b1;
    step(11);
    checks++;
    if (INT !== 1'b0) begin
      errors++;
      $display("FAIL int_early got %b want 0 at cycle 11", INT);
    end
    step(1);
    checks++;
    if (INT !== 1'b1) begin
      errors++;
      $display("FAIL int_latency got %b want 1 at cycle 12", INT);
    end
    io_read(8'h7E, r);
    checks++;
    if (r !== 8'h01) begin
      errors++;
      $display("FAIL pend_read got %h want 01", r);
    end
    step(8);
    BUTTONS[0] = 1'b0;
    step(20);
  endtask

  task automatic test_ack();
    logic [7:0] r;
    io_write(8'h7F, 8'h01, 1'b1);
    checks++;
    if (INT !== 1'b1) begin
      errors++;
      $display("FAIL ack_int1 got %b want 1", INT);
    end
    step(1);
    checks++;
    if (INT !== 1'b0) begin
      errors++;
      $display("FAIL ack_int2 got %b want 0", INT);
    end
    BUTTONS[0] = 1'b1;
    step(10);
    io_write(8'h7F, 8'h01, 1'b1);
    io_read(8'h7E, r);
    checks++;
    if (r !== 8'h01) begin
      errors++;
      $display("FAIL set_wins got %h want 01", r);
    end
    step(4);
    BUTTONS[0] = 1'b0;
    step(20);
    io_write(8'h7F, 8'h0F, 1'b1);
    step(2);
  endtask

  task automatic test_masked_then_reset();
    logic [7:0] r;
    io_write(8'h7D, 8'h00, 1'b1);
    BUTTONS[2] = 1'b1;
    step(12);
    BUTTONS[2] = 1'b0;
    step(20);
    io_read(8'h7E, r);
    checks++;
    if (r !== 8'h04) begin
      errors++;
      $display("FAIL masked_pend got %h want 04", r);
    end
    checks++;
    if (INT !== 1'b0) begin
      errors++;
      $display("FAIL masked_int got %b want 0", INT);
    end
    io_write(8'h7D, 8'h04, 1'b1);
    step(1);
    checks++;
    if (INT !== 1'b1) begin
      errors++;
      $display("FAIL unmask_int got %b want 1", INT);
    end
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    checks++;
    if (INT !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got %b want 0", INT);
    end
    io_read(8'h7E, r);
    checks++;
    if (r !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_pend got %h want 00", r);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [7:0] d;
    int op;
    int b;
    int len;
    m_leds = 16'h0;
    m_sseg = 8'h0;
    m_mask = 4'h0;
    m_pend = 4'h0;
    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 5);
      d  = 8'($urandom);
      case (op)
        0: begin
          if ($urandom_range(0, 1) == 1) begin
            io_write(8'h40, d, 1'b1);
            m_leds = {m_leds[15:8], d};
          end else begin
            io_write(8'h41, d, 1'b1);
            m_leds = {d, m_leds[7:0]};
          end
        end
        1: begin
          if ($urandom_range(0, 1) == 1) begin
            io_write(8'h81, d, 1'b1);
            m_sseg = d;
          end else begin
            io_write(8'h81, d, 1'b0);
          end
        end
        2: begin
          io_write(8'h7D, d, 1'b1);
          m_mask = d[3:0];
        end
        3: begin
          io_write(8'h7F, d, 1'b1);
          m_pend = m_pend & ~d[3:0];
        end
        4: begin
          b   = $urandom_range(0, 3);
          len = $urandom_range(1, 2 * DC);
          BUTTONS[b] = 1'b1;
          step(len);
          BUTTONS[b] = 1'b0;
          step(30);
          if (len >= DC) m_pend[b] = 1'b1;
        end
        default: begin
          SWITCHES = 16'($urandom);
          step(3);
          io_read(8'h20, r);
          checks++;
          if (r !== SWITCHES[7:0]) begin
            errors++;
            $display("FAIL rnd_sw_lo got %h want %h", r, SWITCHES[7:0]);
          end
          io_read(8'h21, r);
          checks++;
          if (r !== SWITCHES[15:8]) begin
            errors++;
            $display("FAIL rnd_sw_hi got %h want %h", r, SWITCHES[15:8]);
          end
        end
      endcase
      step(2);
      checks++;
      if (LEDS !== m_leds) begin
        errors++;
        $display("FAIL rnd_leds it=%0d got %h want %h", it, LEDS, m_leds);
      end
      checks++;
      if (SSEG_VAL !== m_sseg) begin
        errors++;
        $display("FAIL rnd_sseg it=%0d got %h want %h", it, SSEG_VAL, m_sseg);
      end
      io_read(8'h7E, r);
      checks++;
      if (r !== {4'b0, m_pend}) begin
        errors++;
        $display("FAIL rnd_pend it=%0d got %h want %h", it, r, m_pend);
      end
      io_read(8'h7D, r);
      checks++;
      if (r !== {4'b0, m_mask}) begin
        errors++;
        $display("FAIL rnd_mask it=%0d got %h want %h", it, r, m_mask);
      end
      io_read(8'h24, r);
      checks++;
      if (r !== 8'h00) begin
        errors++;
        $display("FAIL rnd_btn it=%0d got %h want 00", it, r);
      end
      checks++;
      if (INT !== |(m_pend & m_mask)) begin
        errors++;
        $display("FAIL rnd_int it=%0d got %b want %b", it, INT,
                 |(m_pend & m_mask));
      end
    end
  endtask

  initial begin
    RESET    = 1'b1;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;
    SWITCHES = 16'h0;
    BUTTONS  = 4'h0;
    step(1);
    test_reset();
    test_leds();
    test_switches();
    test_button_int();
    test_ack();
    test_masked_then_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
